// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter: loader > round-robin fetch/data, fixed read latency
// Optional loader write port compiled in with MEM_ARB_LOADER_EN.
module mem_arbiter #(
   parameter int AW      = 12,
   parameter int MEM_LAT = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [3:0]    d_be,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
`ifdef MEM_ARB_LOADER_EN
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_wdata,
   output logic          ld_gnt,
`endif
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          busy
);

   localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          owner_d_q;
   logic          last_d_q;
   logic          if_rvalid_q, d_rvalid_q, busy_q;
   logic [31:0]   if_rdata_q, d_rdata_q;

   logic idle, ld_win, if_win, d_win;

   assign idle = (state_q == S_IDLE) && !RST;
`ifdef MEM_ARB_LOADER_EN
   assign ld_win = idle && ld_req;
   assign ld_gnt = ld_win;
`else
   assign ld_win = 1'b0;
`endif
   // last_d_q=1 hands a tie to fetch, last_d_q=0 hands it to data
   assign if_win = idle && !ld_win && if_req && !(d_req && !last_d_q);
   assign d_win  = idle && !ld_win && d_req && (!if_req || !last_d_q);

   assign if_gnt    = if_win;
   assign d_gnt     = d_win;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = busy_q;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = 4'b0000;
      mem_wdata = 32'h0;
`ifdef MEM_ARB_LOADER_EN
      if (ld_win) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = ld_addr;
         mem_be    = 4'b1111;
         mem_wdata = ld_wdata;
      end else
`endif
      if (if_win) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
         mem_be   = 4'b1111;
      end else if (d_win) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_be    = d_be;
         mem_wdata = d_wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         owner_d_q   <= 1'b0;
         last_d_q    <= 1'b1;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= 32'h0;
         d_rdata_q   <= 32'h0;
         busy_q      <= 1'b0;
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (if_win) begin
                  last_d_q  <= 1'b0;
                  owner_d_q <= 1'b0;
                  cnt_q     <= CW'(MEM_LAT);
                  busy_q    <= 1'b1;
                  state_q   <= S_WAIT;
               end else if (d_win) begin
                  last_d_q <= 1'b1;
                  if (!d_we) begin
                     owner_d_q <= 1'b1;
                     cnt_q     <= CW'(MEM_LAT);
                     busy_q    <= 1'b1;
                     state_q   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == CW'(1)) begin
                  if (owner_d_q) begin
                     d_rdata_q  <= mem_rdata;
                     d_rvalid_q <= 1'b1;
                  end else begin
                     if_rdata_q  <= mem_rdata;
                     if_rvalid_q <= 1'b1;
                  end
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with a latency-accurate memory model
module tb_mem_arbiter;
   localparam int AW  = 12;
   localparam int LAT = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [3:0]    d_be;
   logic [31:0]   d_wdata;
   logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [31:0]   if_rdata, d_rdata;
   logic          mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata, mem_rdata;
`ifdef MEM_ARB_LOADER_EN
   logic          ld_req, ld_gnt;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_wdata;
`endif

   mem_arbiter #(.AW(AW), .MEM_LAT(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MEM_ARB_LOADER_EN
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] init_pat(input logic [AW-1:0] a);
      return {a, 4'hA, a ^ 12'h5A5, 4'h3};
   endfunction

   // Memory model: read data appears LAT cycles after the issuing cycle
   logic [31:0] m [0:(1<<AW)-1];
   bit          m_wr [0:(1<<AW)-1];
   logic [31:0] pipe [0:LAT-1];
   logic [31:0] cur;
   assign mem_rdata = pipe[LAT-1];

   always @(posedge CLK) begin
      cur = m_wr[mem_addr] ? m[mem_addr] : init_pat(mem_addr);
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= cur;
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
         m[mem_addr]    <= cur;
         m_wr[mem_addr] <= 1'b1;
      end
   end

   typedef struct { int due; bit is_d; logic [31:0] data; } sb_t;
   sb_t         sb [$];
   logic [31:0] shadow [0:(1<<AW)-1];
   bit          sh_wr [0:(1<<AW)-1];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
      return sh_wr[a] ? shadow[a] : init_pat(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic mon();
      sb_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("rvalid_owner", {30'd0, if_rvalid, d_rvalid}, e.is_d ? 32'd1 : 32'd2);
         chk("rdata", e.is_d ? d_rdata : if_rdata, e.data);
      end else begin
         chk("no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
      cyc++;
      mon();
   endtask

   task automatic gchk(input string tag, input bit is_d, input bit we,
                       input logic [AW-1:0] a, input logic [3:0] be);
      chk({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, is_d ? 32'd1 : 32'd2);
      chk({tag, "_en"}, {31'd0, mem_en}, 32'd1);
      chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
      chk({tag, "_addr"}, {20'd0, mem_addr}, {20'd0, a});
      chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, be});
      if (!we) sb.push_back('{cyc + LAT + 1, is_d, exp_word(a)});
   endtask

   task automatic reset_dut();
      cycle();
      RST = 1'b1;
      if_req = 1'b0;
      d_req = 1'b0;
      sb.delete();
      cycle();
      cycle();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = 4'b0000; d_wdata = 32'h0;
`ifdef MEM_ARB_LOADER_EN
      ld_req = 1'b0; ld_addr = '0; ld_wdata = 32'h0;
`endif
      reset_dut();
      #1;
      chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
      chk("rst_rdata_if", if_rdata, 32'h0);
      chk("rst_rdata_d", d_rdata, 32'h0);
      chk("rst_mem", {mem_en, mem_we, mem_be, 14'd0, mem_addr}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // Single fetch
      if_req = 1'b1; if_addr = AW'(12'h004);
      #1;
      gchk("f1", 1'b0, 1'b0, AW'(12'h004), 4'b1111);
      cycle();
      if_req = 1'b0;
      #1;
      chk("f1_busy", {31'd0, busy}, 32'd1);
      chk("f1_wait_en", {31'd0, mem_en}, 32'd0);
      repeat (LAT) cycle();
      chk("f1_drain", sb.size(), 32'd0);
      cycle();
      chk("f1_hold", if_rdata, exp_word(AW'(12'h004)));
      chk("f1_idle_busy", {31'd0, busy}, 32'd0);

      // Simultaneous fetch and load after reset: fetch first
      reset_dut();
      if_req = 1'b1; if_addr = AW'(12'h010);
      d_req = 1'b1; d_we = 1'b0; d_addr = AW'(12'h020); d_be = 4'b1111;
      #1;
      gchk("tie_f", 1'b0, 1'b0, AW'(12'h010), 4'b1111);
      for (int j = 0; j < LAT; j++) begin
         cycle();
         if_req = 1'b0;
         #1;
         chk("tie_wait", {30'd0, if_gnt, d_gnt}, 32'd0);
      end
      cycle();
      #1;
      gchk("tie_d", 1'b1, 1'b0, AW'(12'h020), 4'b1111);
      cycle();
      d_req = 1'b0;
      repeat (LAT + 1) cycle();
      chk("tie_drain", sb.size(), 32'd0);

      // Half-word store, then fetch the same word the next cycle
      d_req = 1'b1; d_we = 1'b1; d_addr = AW'(12'h020); d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
      #1;
      gchk("st", 1'b1, 1'b1, AW'(12'h020), 4'b0011);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      shadow[AW'(12'h020)] = {init_pat(AW'(12'h020)) >> 16, 16'hBEEF};
      sh_wr[AW'(12'h020)] = 1'b1;
      cycle();
      d_req = 1'b0; d_we = 1'b0;
      if_req = 1'b1; if_addr = AW'(12'h020);
      #1;
      gchk("st_f", 1'b0, 1'b0, AW'(12'h020), 4'b1111);

      // Reset in the second WAIT cycle aborts that fetch
      cycle();
      if_req = 1'b0;
      cycle();
      RST = 1'b1;
      sb.delete();
      cycle();
      RST = 1'b0;
      #1;
      chk("abort_rdata", if_rdata, 32'h0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      cycle();

      // Both held: alternate fetch, data every LAT+1 cycles
      if_req = 1'b1; if_addr = AW'(12'h200);
      d_req = 1'b1; d_we = 1'b0; d_addr = AW'(12'h300); d_be = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (k % 2 == 0) gchk("alt_f", 1'b0, 1'b0, if_addr, 4'b1111);
         else            gchk("alt_d", 1'b1, 1'b0, d_addr, 4'b0001);
         for (int j = 0; j < LAT; j++) begin
            cycle();
            #1;
            chk("alt_wait", {30'd0, if_gnt, d_gnt}, 32'd0);
         end
         cycle();
         if_addr = AW'(12'h200 + k + 1);
         d_addr  = AW'(12'h300 + k + 1);
      end
      if_req = 1'b0;
      d_req = 1'b0;
      repeat (LAT + 2) cycle();
      chk("alt_drain", sb.size(), 32'd0);

`ifdef MEM_ARB_LOADER_EN
      // Loader starves fetch while held
      if_req = 1'b1; if_addr = AW'(12'h040);
      ld_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ld_addr = AW'(12'h100 + k);
         ld_wdata = 32'h1000_0000 + k;
         #1;
         chk("ld_gnt", {29'd0, ld_gnt, if_gnt, d_gnt}, 32'd4);
         chk("ld_mem", {mem_en, mem_we, mem_be}, 6'b111111);
         chk("ld_addr", {20'd0, mem_addr}, {20'd0, ld_addr});
         cycle();
      end
      ld_req = 1'b0;
      #1;
      gchk("ld_f", 1'b0, 1'b0, AW'(12'h040), 4'b1111);
      cycle();
      if_req = 1'b0;
      repeat (LAT + 1) cycle();
      chk("ld_drain", sb.size(), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
